// File: rtl/fft_test_sys_pio_out.sv
// fft_test_sys_pio_out
//
// Avalon-MM slave output PIO for the FFT test system. A CPU-writable data
// register drives out_port. Atomic bit set/clear registers modify it without
// read-modify-write. A one-shot pulse generator ORs a mask onto the output
// for a programmable number of clock cycles.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address (0 DATA, 1 PW, 2 PULSE, 3 STATUS,
//               4 OUTSET, 5 OUTCLEAR, 6/7 unmapped)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data, one cycle after address
//   out_port    PIO output, data register with pulse overlay
module fft_test_sys_pio_out #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    CNT_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [CNT_WIDTH-1:0]  DEFAULT_PW  = CNT_WIDTH'(1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_PW       = 3'd1;
    localparam logic [2:0] ADDR_PULSE    = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  pw_q, pw_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [31:0]           readdata_q, readdata_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;

    logic                  wr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  unused_wdata;

    assign wr    = chipselect && !write_n;
    assign wdata = writedata[DATA_WIDTH-1:0];
    // Upper write-data bits are architecturally ignored.
    assign unused_wdata = ^writedata;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pw_d    = pw_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;

        if (wr) begin
            case (address)
                ADDR_DATA:     data_d = wdata;
                ADDR_PW:       pw_d   = writedata[CNT_WIDTH-1:0];
                ADDR_OUTSET:   data_d = data_q | wdata;
                ADDR_OUTCLEAR: data_d = data_q & ~wdata;
                default:       ;
            endcase
        end

        // A PULSE write (trigger or retrigger) takes priority over the
        // countdown. With pw_reg==0 it forces IDLE, which aborts an active
        // pulse and is a no-op when already idle.
        if (wr && address == ADDR_PULSE) begin
            if (pw_q != '0) begin
                state_d = ACTIVE;
                mask_d  = wdata;
                cnt_d   = pw_q;
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
                mask_d  = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        end else if (state_q == ACTIVE) begin
            if (cnt_q == CNT_WIDTH'(1)) begin
                state_d = IDLE;
                mask_d  = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
        end
    end

    // Read mux reflects the current register contents, independent of
    // chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:   readdata_d = 32'(data_q);
            ADDR_PW:     readdata_d = 32'(pw_q);
            ADDR_PULSE:  readdata_d = 32'(mask_q);
            ADDR_STATUS: readdata_d = (32'(cnt_q) << 1) | 32'(busy_q);
            default:     readdata_d = '0;
        endcase
    end

    // out_port is registered from next-state values so a write at edge k
    // appears right after edge k with no combinational bus-to-pin path.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
            assign out_d[gi] = data_d[gi] | (busy_d & mask_d[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            data_q     <= RESET_VALUE;
            pw_q       <= DEFAULT_PW;
            mask_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            readdata_q <= '0;
            out_q      <= RESET_VALUE;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            pw_q       <= pw_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            readdata_q <= readdata_d;
            out_q      <= out_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_q;

endmodule

// File: tb/tb_fft_test_sys_pio_out.sv
// Testbench for fft_test_sys_pio_out (default parameters). Each scenario
// builds a table of bus cycles; expected out_port/readdata values are pushed
// to a scoreboard queue as each cycle is driven and popped for comparison
// after the clock edge.
module tb_fft_test_sys_pio_out;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } row_t;

    row_t sb[$];

    fft_test_sys_pio_out dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1);
    end

    function automatic row_t W(input logic [2:0] a, input logic [31:0] d, input logic [7:0] eo);
        row_t r;
        r.we = 1'b1; r.addr = a; r.wd = d; r.exp_out = eo; r.chk_rd = 1'b0; r.exp_rd = '0;
        return r;
    endfunction

    function automatic row_t R(input logic [2:0] a, input logic [7:0] eo, input logic [31:0] er);
        row_t r;
        r.we = 1'b0; r.addr = a; r.wd = '0; r.exp_out = eo; r.chk_rd = 1'b1; r.exp_rd = er;
        return r;
    endfunction

    // Drive one bus cycle and record its expectation; returns #1 after the edge.
    task automatic drive_row(input row_t r);
        @(negedge clk);
        address    = r.addr;
        write_n    = !r.we;
        chipselect = r.we ? 1'b1 : 1'($urandom_range(0, 1));
        writedata  = r.we ? r.wd : $urandom;
        sb.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
    endtask

    task automatic test_reset();
        row_t rows[$];
        row_t e;
        reset_n = 1'b0;
        bus_idle();
        repeat (2) @(negedge clk);
        total_cnt++;
        if (out_port !== 8'h00) $display("FAIL reset_out_port got 0x%0h want 0x00", out_port);
        else pass_cnt++;
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL reset_readdata got 0x%0h want 0x0", readdata);
        else pass_cnt++;
        reset_n = 1'b1;
        rows.push_back(R(3'd0, 8'h00, 32'h0));
        rows.push_back(R(3'd1, 8'h00, 32'h1));
        rows.push_back(R(3'd3, 8'h00, 32'h0));
        rows.push_back(W(3'd0, 32'h55, 8'h55));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.exp_out) $display("FAIL reset row %0d out_port got 0x%0h want 0x%0h", i, out_port, e.exp_out);
            else pass_cnt++;
            if (e.chk_rd) begin
                total_cnt++;
                if (readdata !== e.exp_rd) $display("FAIL reset row %0d readdata got 0x%0h want 0x%0h", i, readdata, e.exp_rd);
                else pass_cnt++;
            end
        end
        // Asynchronous assertion away from any clock edge.
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if (out_port !== 8'h00) $display("FAIL async_reset_out_port got 0x%0h want 0x00", out_port);
        else pass_cnt++;
        @(negedge clk);
        bus_idle();
        reset_n = 1'b1;
    endtask

    task automatic test_set_clear();
        row_t rows[$];
        row_t e;
        rows.push_back(W(3'd0, 32'hA5, 8'hA5));
        rows.push_back(W(3'd4, 32'h0F, 8'hAF));
        rows.push_back(W(3'd5, 32'h81, 8'h2E));
        rows.push_back(R(3'd0, 8'h2E, 32'h2E));
        rows.push_back(R(3'd4, 8'h2E, 32'h0));
        rows.push_back(R(3'd5, 8'h2E, 32'h0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.exp_out) $display("FAIL set_clear row %0d out_port got 0x%0h want 0x%0h", i, out_port, e.exp_out);
            else pass_cnt++;
            if (e.chk_rd) begin
                total_cnt++;
                if (readdata !== e.exp_rd) $display("FAIL set_clear row %0d readdata got 0x%0h want 0x%0h", i, readdata, e.exp_rd);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_pulse();
        row_t rows[$];
        row_t e;
        rows.push_back(W(3'd0, 32'h00, 8'h00));
        rows.push_back(W(3'd1, 32'h3, 8'h00));
        rows.push_back(W(3'd2, 32'h10, 8'h10));
        rows.push_back(R(3'd3, 8'h10, 32'h7));
        rows.push_back(R(3'd3, 8'h10, 32'h5));
        rows.push_back(R(3'd3, 8'h00, 32'h3));
        rows.push_back(R(3'd3, 8'h00, 32'h0));
        rows.push_back(R(3'd1, 8'h00, 32'h3));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.exp_out) $display("FAIL pulse row %0d out_port got 0x%0h want 0x%0h", i, out_port, e.exp_out);
            else pass_cnt++;
            if (e.chk_rd) begin
                total_cnt++;
                if (readdata !== e.exp_rd) $display("FAIL pulse row %0d readdata got 0x%0h want 0x%0h", i, readdata, e.exp_rd);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_retrigger();
        row_t rows[$];
        row_t e;
        rows.push_back(W(3'd1, 32'h5, 8'h00));
        rows.push_back(W(3'd2, 32'h01, 8'h01));
        rows.push_back(R(3'd2, 8'h01, 32'h01));
        rows.push_back(W(3'd2, 32'h02, 8'h02));
        for (int k = 0; k < 4; k++) rows.push_back(R(3'd2, 8'h02, 32'h02));
        rows.push_back(R(3'd2, 8'h00, 32'h02));
        rows.push_back(R(3'd2, 8'h00, 32'h00));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.exp_out) $display("FAIL retrigger row %0d out_port got 0x%0h want 0x%0h", i, out_port, e.exp_out);
            else pass_cnt++;
            if (e.chk_rd) begin
                total_cnt++;
                if (readdata !== e.exp_rd) $display("FAIL retrigger row %0d readdata got 0x%0h want 0x%0h", i, readdata, e.exp_rd);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_pw_zero();
        row_t rows[$];
        row_t e;
        rows.push_back(W(3'd1, 32'h0, 8'h00));
        rows.push_back(W(3'd2, 32'hFF, 8'h00));
        rows.push_back(R(3'd3, 8'h00, 32'h0));
        rows.push_back(W(3'd1, 32'h4, 8'h00));
        rows.push_back(W(3'd2, 32'h01, 8'h01));
        rows.push_back(W(3'd1, 32'h0, 8'h01));
        rows.push_back(W(3'd2, 32'h02, 8'h00));
        rows.push_back(R(3'd3, 8'h00, 32'h0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.exp_out) $display("FAIL pw_zero row %0d out_port got 0x%0h want 0x%0h", i, out_port, e.exp_out);
            else pass_cnt++;
            if (e.chk_rd) begin
                total_cnt++;
                if (readdata !== e.exp_rd) $display("FAIL pw_zero row %0d readdata got 0x%0h want 0x%0h", i, readdata, e.exp_rd);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_data_during_pulse();
        row_t rows[$];
        row_t e;
        rows.push_back(W(3'd1, 32'h2, 8'h00));
        rows.push_back(W(3'd0, 32'h01, 8'h01));
        rows.push_back(W(3'd2, 32'h03, 8'h03));
        rows.push_back(W(3'd4, 32'h40, 8'h43));
        rows.push_back(R(3'd3, 8'h41, 32'h3));
        rows.push_back(W(3'd2, 32'h00, 8'h41));
        rows.push_back(R(3'd3, 8'h41, 32'h5));
        rows.push_back(R(3'd3, 8'h41, 32'h3));
        rows.push_back(R(3'd3, 8'h41, 32'h0));
        rows.push_back(W(3'd3, 32'hFF, 8'h41));
        rows.push_back(W(3'd6, 32'hFF, 8'h41));
        rows.push_back(W(3'd7, 32'hFF, 8'h41));
        rows.push_back(R(3'd6, 8'h41, 32'h0));
        rows.push_back(R(3'd7, 8'h41, 32'h0));
        rows.push_back(W(3'd0, 32'hFFFF_FF41, 8'h41));
        rows.push_back(R(3'd0, 8'h41, 32'h41));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.exp_out) $display("FAIL data_during_pulse row %0d out_port got 0x%0h want 0x%0h", i, out_port, e.exp_out);
            else pass_cnt++;
            if (e.chk_rd) begin
                total_cnt++;
                if (readdata !== e.exp_rd) $display("FAIL data_during_pulse row %0d readdata got 0x%0h want 0x%0h", i, readdata, e.exp_rd);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        row_t rows[$];
        row_t post[$];
        row_t e;
        rows.push_back(W(3'd0, 32'h00, 8'h00));
        rows.push_back(W(3'd1, 32'hA, 8'h00));
        rows.push_back(W(3'd2, 32'h80, 8'h80));
        rows.push_back(R(3'd3, 8'h80, 32'h15));
        rows.push_back(R(3'd3, 8'h80, 32'h13));
        rows.push_back(R(3'd3, 8'h80, 32'h11));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.exp_out) $display("FAIL reset_mid_pulse row %0d out_port got 0x%0h want 0x%0h", i, out_port, e.exp_out);
            else pass_cnt++;
            if (e.chk_rd) begin
                total_cnt++;
                if (readdata !== e.exp_rd) $display("FAIL reset_mid_pulse row %0d readdata got 0x%0h want 0x%0h", i, readdata, e.exp_rd);
                else pass_cnt++;
            end
        end
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if (out_port !== 8'h00) $display("FAIL mid_pulse_async_out_port got 0x%0h want 0x00", out_port);
        else pass_cnt++;
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL mid_pulse_async_readdata got 0x%0h want 0x0", readdata);
        else pass_cnt++;
        @(negedge clk);
        bus_idle();
        reset_n = 1'b1;
        post.push_back(R(3'd3, 8'h00, 32'h0));
        post.push_back(R(3'd1, 8'h00, 32'h1));
        post.push_back(R(3'd2, 8'h00, 32'h0));
        foreach (post[i]) begin
            drive_row(post[i]);
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.exp_out) $display("FAIL after_reset row %0d out_port got 0x%0h want 0x%0h", i, out_port, e.exp_out);
            else pass_cnt++;
            total_cnt++;
            if (readdata !== e.exp_rd) $display("FAIL after_reset row %0d readdata got 0x%0h want 0x%0h", i, readdata, e.exp_rd);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_pulse();
        test_retrigger();
        test_pw_zero();
        test_data_during_pulse();
        test_reset_mid_pulse();
        @(negedge clk);
        bus_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
